uart_fifo_mmio: RTL and testbench

UART_FIFO_MMIO -- requirements
Module: uart_fifo_mmio

---
 rtl/uart_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_rx.sv | 80 ++++++++
 rtl/uart_tx.sv | 81 ++++++++
 rtl/uart_fifo_mmio.sv | 161 ++++++++++++++++
 tb/tb_uart_fifo_mmio.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared register map, CTRL/STAT bit positions and TX drain FSM states
// for the MMIO UART with TX/RX FIFOs.
package uart_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STAT     = 3'd1;
  localparam logic [2:0] ADDR_TX       = 3'd2;
  localparam logic [2:0] ADDR_RX       = 3'd3;
  localparam logic [2:0] ADDR_RX_LEVEL = 3'd4;
  localparam logic [2:0] ADDR_TX_LEVEL = 3'd5;

  localparam int unsigned CTRL_TX_EN     = 0;
  localparam int unsigned CTRL_RX_EN     = 1;
  localparam int unsigned CTRL_RX_IRQ_EN = 2;
  localparam int unsigned CTRL_TX_IRQ_EN = 3;
  localparam int unsigned CTRL_TX_FLUSH  = 4;
  localparam int unsigned CTRL_RX_FLUSH  = 5;

  localparam int unsigned STAT_RX_NOT_EMPTY = 0;
  localparam int unsigned STAT_TX_NOT_FULL  = 1;
  localparam int unsigned STAT_TX_EMPTY     = 2;
  localparam int unsigned STAT_RX_FULL      = 3;
  localparam int unsigned STAT_RX_OVERRUN   = 4;
  localparam int unsigned STAT_TX_BUSY      = 5;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush, full-depth occupancy counter
// and a combinational head output.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push at full still succeeds.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid handshake.
module uart_rx #(
  parameter int unsigned CLK_FRE   = 27,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  input  logic       rx_pin
);

  localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

  rx_state_t   state;
  logic [1:0]  rx_sync;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rx_bit;

  assign rx_bit = rx_sync[1];

  // Line synchroniser, bit timing and byte assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rx_sync       <= 2'b11;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_pin};
      if (rx_data_valid && rx_data_ready) rx_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_bit) state <= S_START;
        end
        S_START: begin
          if (cnt == CYCLE/2 - 1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_bit ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CYCLE - 1) begin
            cnt   <= '0;
            shreg <= {rx_bit, shreg[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CYCLE - 1) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (rx_bit) begin
              rx_data       <= shreg;
              rx_data_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; ready is high only while idle.
module uart_tx #(
  parameter int unsigned CLK_FRE   = 27,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_pin
);

  localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_core_state_t;

  tx_core_state_t state;
  logic [31:0]    cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  assign tx_data_ready = (state == S_IDLE);

  // Frame sequencing: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_pin  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          cnt    <= '0;
          tx_pin <= 1'b1;
          if (tx_data_valid) begin
            shreg  <= tx_data;
            tx_pin <= 1'b0;
            state  <= S_START;
          end
        end
        S_START: begin
          if (cnt == CYCLE - 1) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx_pin  <= shreg[0];
            state   <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CYCLE - 1) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_pin <= 1'b1;
              state  <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx_pin  <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CYCLE - 1) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_mmio.sv
// MMIO UART: CTRL/STAT registers, TX and RX FIFOs, TX drain FSM, level irq.
module uart_fifo_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE  = 27,
  parameter int unsigned UART_FRE = 115200,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_pin,
  output logic       uart_tx_pin,
  input  logic [2:0] addr,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       irq
);

  localparam int unsigned TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_LW = $clog2(RX_DEPTH) + 1;

  logic             rst_n;
  logic [3:0]       ctrl;
  tx_state_t        tx_state;
  logic             rx_overrun;

  logic             wr_ctrl, wr_stat, wr_tx, rx_pop;
  logic             tx_flush, rx_flush;

  logic             tx_full, tx_empty, tx_pop;
  logic [TX_LW-1:0] tx_level;
  logic [7:0]       tx_head;
  logic             tx_valid, tx_ready;

  logic             rx_full, rx_empty, rx_push;
  logic [RX_LW-1:0] rx_level;
  logic [7:0]       rx_head;
  logic [7:0]       rx_byte;
  logic             rx_valid;

  logic             tx_busy, overrun_set;
  logic [7:0]       stat;

  assign rst_n    = ~rst;

  assign wr_ctrl  = wr_en && (addr == ADDR_CTRL);
  assign wr_stat  = wr_en && (addr == ADDR_STAT);
  assign wr_tx    = wr_en && (addr == ADDR_TX);
  assign rx_pop   = rd_en && (addr == ADDR_RX);
  assign tx_flush = wr_ctrl && wr_data[CTRL_TX_FLUSH];
  assign rx_flush = wr_ctrl && wr_data[CTRL_RX_FLUSH];

  assign rx_push  = rx_valid && ctrl[CTRL_RX_EN];
  // A pop coinciding with the byte arrival frees a slot, so no overrun then.
  assign overrun_set = rx_push && rx_full && !rx_pop;

  assign tx_valid = (tx_state == TX_LOAD) && !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_busy  = !tx_empty || !tx_ready || (tx_state != TX_IDLE);

  assign stat = {2'b00, tx_busy, rx_overrun, rx_full, tx_empty, !tx_full, !rx_empty};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) tx_fifo_inst (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (wr_data),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rx_fifo_inst (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_byte),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level),
    .head  (rx_head)
  );

  uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(UART_FRE)) uart_rx_inst (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_byte),
    .rx_data_valid (rx_valid),
    .rx_data_ready (1'b1),
    .rx_pin        (uart_rx_pin)
  );

  uart_tx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(UART_FRE)) uart_tx_inst (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_head),
    .tx_data_valid (tx_valid),
    .tx_data_ready (tx_ready),
    .tx_pin        (uart_tx_pin)
  );

  // CTRL register; flush bits are strobes and are not stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctrl <= '0;
    else if (wr_ctrl) ctrl <= wr_data[3:0];
  end

  // Sticky overrun flag; a new overrun beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_overrun <= 1'b0;
    else if (overrun_set) rx_overrun <= 1'b1;
    else if (wr_stat && wr_data[STAT_RX_OVERRUN]) rx_overrun <= 1'b0;
  end

  // TX drain: hand the FIFO head to the serializer one byte at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
    end else begin
      case (tx_state)
        TX_IDLE: if (ctrl[CTRL_TX_EN] && !tx_empty) tx_state <= TX_LOAD;
        TX_LOAD: begin
          // A flush can empty the FIFO under us; fall back rather than stall.
          if (tx_empty) tx_state <= TX_IDLE;
          else if (tx_ready) tx_state <= TX_WAIT;
        end
        TX_WAIT: if (tx_ready) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else irq <= (ctrl[CTRL_RX_IRQ_EN] && (!rx_empty || rx_overrun)) ||
                (ctrl[CTRL_TX_IRQ_EN] && tx_empty);
  end

  // Combinational register read mux.
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_CTRL:     rd_data = {4'b0000, ctrl};
      ADDR_STAT:     rd_data = stat;
      ADDR_RX:       rd_data = rx_empty ? 8'h00 : rx_head;
      ADDR_RX_LEVEL: rd_data = 8'(rx_level);
      ADDR_TX_LEVEL: rd_data = 8'(tx_level);
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Directed bench for uart_fifo_mmio: 4-entry FIFOs, 10 clocks per UART bit.
module tb_uart_fifo_mmio;
  import uart_pkg::*;

  localparam int BIT = 10;   // 1 MHz / 100 kbaud

  logic       clk;
  logic       rst;
  logic       uart_rx_pin;
  logic       uart_tx_pin;
  logic [2:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] txq[$];
  logic [7:0] v;
  logic [7:0] race_byte;
  logic       found;

  uart_fifo_mmio #(
    .CLK_FRE  (1),
    .UART_FRE (100000),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx_pin (uart_rx_pin),
    .uart_tx_pin (uart_tx_pin),
    .addr        (addr),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    #1 d = rd_data;
  endtask

  task automatic pop_rx(output logic [7:0] d);
    @(negedge clk);
    addr = ADDR_RX; rd_en = 1'b1;
    #1 d = rd_data;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_pin = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx_pin = 1'b1;
    repeat (BIT + 3) @(negedge clk);
  endtask

  // Serial line decoder for the transmit pin.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx_pin === 1'b0 && rst === 1'b0) begin
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = uart_tx_pin;
        end
        txq.push_back(b);
        repeat (BIT) @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; uart_rx_pin = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_pin", {7'd0, uart_tx_pin}, 8'h01);
    check("rst_irq", {7'd0, irq}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    peek(ADDR_STAT, v);     check("rst_stat", v, 8'h06);
    peek(ADDR_CTRL, v);     check("rst_ctrl", v, 8'h00);

    // TX ordering: stack five bytes while tx_en=0 so the fifth hits a full FIFO.
    for (int i = 0; i < 5; i++) wr(ADDR_TX, 8'h41 + 8'(i));
    peek(ADDR_TX_LEVEL, v); check("tx_level_peak", v, 8'h04);
    peek(ADDR_STAT, v);     check("tx_full_stat", v, 8'h20);
    peek(ADDR_TX, v);       check("tx_reg_reads0", v, 8'h00);
    txq.delete();
    wr(ADDR_CTRL, 8'h01);
    for (int i = 0; i < 800 && txq.size() < 4; i++) @(negedge clk);
    repeat (150) @(negedge clk);
    check("tx_count", 8'(txq.size()), 8'h04);
    for (int i = 0; i < 4; i++)
      check("tx_byte", (txq.size() > i) ? txq[i] : 8'hxx, 8'h41 + 8'(i));
    peek(ADDR_TX_LEVEL, v); check("tx_level_end", v, 8'h00);
    peek(ADDR_STAT, v);     check("tx_idle_stat", v, 8'h06);

    // RX overrun: fifth byte dropped into a full 4-entry FIFO.
    wr(ADDR_CTRL, 8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    peek(ADDR_RX_LEVEL, v); check("rx_level_full", v, 8'h04);
    peek(ADDR_STAT, v);     check("rx_overrun_stat", v, 8'h1F);
    pop_rx(v); check("rx_pop0", v, 8'h11);
    pop_rx(v); check("rx_pop1", v, 8'h22);
    pop_rx(v); check("rx_pop2", v, 8'h33);
    pop_rx(v); check("rx_pop3", v, 8'h44);
    pop_rx(v); check("rx_pop_empty", v, 8'h00);
    peek(ADDR_RX_LEVEL, v); check("rx_level_empty", v, 8'h00);
    peek(ADDR_STAT, v);     check("overrun_sticky", v, 8'h16);
    wr(ADDR_STAT, 8'h10);
    peek(ADDR_STAT, v);     check("overrun_clear", v, 8'h06);

    // Full-boundary race: pop exactly when the next byte's valid pulse lands.
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    peek(ADDR_STAT, v);     check("race_pre_stat", v, 8'h0F);
    found = 1'b0; race_byte = '0;
    fork
      send_byte(8'h55);
      begin
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge clk);
          if (dut.rx_valid === 1'b1) begin
            addr = ADDR_RX; rd_en = 1'b1;
            #1 race_byte = rd_data;
            @(negedge clk);
            rd_en = 1'b0;
            found = 1'b1;
          end
        end
      end
    join
    check("race_seen", {7'd0, found}, 8'h01);
    check("race_pop", race_byte, 8'h11);
    peek(ADDR_RX_LEVEL, v); check("race_level", v, 8'h04);
    peek(ADDR_STAT, v);     check("race_no_overrun", v, 8'h0F);
    pop_rx(v); check("race_drain0", v, 8'h22);
    pop_rx(v); check("race_drain1", v, 8'h33);
    pop_rx(v); check("race_drain2", v, 8'h44);
    pop_rx(v); check("race_drain3", v, 8'h55);

    // RX interrupt timing around push and pop.
    wr(ADDR_CTRL, 8'h06);
    check("irq_idle", {7'd0, irq}, 8'h00);
    found = 1'b0;
    fork
      send_byte(8'h5A);
      begin
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge clk);
          if (dut.rx_valid === 1'b1) begin
            @(negedge clk);
            check("irq_at_push", {7'd0, irq}, 8'h00);
            peek(ADDR_RX_LEVEL, v); check("irq_rx_level", v, 8'h01);
            @(negedge clk);
            check("irq_after_push", {7'd0, irq}, 8'h01);
            found = 1'b1;
          end
        end
      end
    join
    check("irq_seen", {7'd0, found}, 8'h01);
    pop_rx(v); check("irq_pop_byte", v, 8'h5A);
    check("irq_at_pop", {7'd0, irq}, 8'h01);
    @(negedge clk);
    check("irq_after_pop", {7'd0, irq}, 8'h00);
    wr(ADDR_CTRL, 8'h08);
    @(negedge clk);
    check("irq_tx_empty", {7'd0, irq}, 8'h01);

    // Flush mid-byte: current byte finishes, queued bytes vanish.
    wr(ADDR_CTRL, 8'h00);
    wr(ADDR_TX, 8'h61); wr(ADDR_TX, 8'h62); wr(ADDR_TX, 8'h63);
    txq.delete();
    wr(ADDR_CTRL, 8'h01);
    repeat (30) @(negedge clk);
    peek(ADDR_TX_LEVEL, v); check("flush_pre_level", v, 8'h02);
    peek(ADDR_STAT, v);     check("flush_pre_stat", v, 8'h22);
    wr(ADDR_CTRL, 8'h11);
    peek(ADDR_TX_LEVEL, v); check("flush_level", v, 8'h00);
    peek(ADDR_CTRL, v);     check("flush_selfclear", v, 8'h01);
    for (int i = 0; i < 300 && txq.size() < 1; i++) @(negedge clk);
    repeat (200) @(negedge clk);
    check("flush_count", 8'(txq.size()), 8'h01);
    check("flush_byte", (txq.size() > 0) ? txq[0] : 8'hxx, 8'h61);
    peek(ADDR_STAT, v);     check("flush_post_stat", v, 8'h06);

    // Reset in the middle of a frame of zero bits.
    wr(ADDR_TX, 8'h00); wr(ADDR_TX, 8'h78);
    repeat (25) @(negedge clk);
    check("mid_frame_low", {7'd0, uart_tx_pin}, 8'h00);
    rst = 1'b1;
    #1;
    check("reset_line_high", {7'd0, uart_tx_pin}, 8'h01);
    peek(ADDR_TX_LEVEL, v); check("reset_tx_level", v, 8'h00);
    peek(ADDR_STAT, v);     check("reset_stat", v, 8'h06);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    peek(ADDR_CTRL, v);     check("reset_ctrl", v, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
